// File: rtl/antares_muldiv_ctrl_pkg.sv
// Shared HI/LO operation codes, sequencer state encoding and op-classification helpers
// for the Antares multiply/divide controller.
package antares_muldiv_ctrl_pkg;

  localparam int unsigned MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_OP_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_OP_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_OP_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_OP_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_OP_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_OP_MADD  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_OP_MADDU = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_OP_MSUB  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_OP_MSUBU = 4'd8;
  localparam logic [MD_OP_W-1:0] MD_OP_MTHI  = 4'd9;
  localparam logic [MD_OP_W-1:0] MD_OP_MTLO  = 4'd10;
  localparam logic [MD_OP_W-1:0] MD_OP_MFHI  = 4'd11;
  localparam logic [MD_OP_W-1:0] MD_OP_MFLO  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MULT_WAIT = 2'd1,
    ST_DIV_WAIT  = 2'd2
  } md_state_e;

  // How the product is folded into {HI,LO} when the multiplier finishes
  typedef enum logic [1:0] {
    ACC_SET = 2'd0,
    ACC_ADD = 2'd1,
    ACC_SUB = 2'd2
  } acc_mode_e;

  function automatic logic is_mult_class(input logic [MD_OP_W-1:0] op);
    case (op)
      MD_OP_MULT, MD_OP_MULTU, MD_OP_MADD,
      MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_op(input logic [MD_OP_W-1:0] op);
    case (op)
      MD_OP_MULT, MD_OP_DIV, MD_OP_MADD, MD_OP_MSUB: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  function automatic acc_mode_e acc_mode(input logic [MD_OP_W-1:0] op);
    case (op)
      MD_OP_MADD, MD_OP_MADDU: return ACC_ADD;
      MD_OP_MSUB, MD_OP_MSUBU: return ACC_SUB;
      default:                 return ACC_SET;
    endcase
  endfunction

endpackage

// File: rtl/antares_muldiv_ctrl_if.sv
// Start/done handshake and operand bus between the HI/LO sequencer (master)
// and the external multiplier/divider engines (slave).
interface antares_muldiv_ctrl_if;
  logic [31:0] eng_a;
  logic [31:0] eng_b;
  logic        mult_start;
  logic        mult_signed;
  logic        mult_done;
  logic [63:0] mult_result;
  logic        div_start;
  logic        div_signed;
  logic        div_done;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  modport master (
    output eng_a, eng_b,
    output mult_start, mult_signed,
    input  mult_done, mult_result,
    output div_start, div_signed,
    input  div_done, div_quotient, div_remainder
  );

  modport slave (
    input  eng_a, eng_b,
    input  mult_start, mult_signed,
    output mult_done, mult_result,
    input  div_start, div_signed,
    output div_done, div_quotient, div_remainder
  );
endinterface

// File: rtl/antares_muldiv_ctrl.sv
// HI/LO owner and multiply/divide sequencer: launches engine ops, commits results
// into HI/LO and stalls later HI/LO consumers while an op is in flight.
module antares_muldiv_ctrl
  import antares_muldiv_ctrl_pkg::*;
#(
  parameter bit ENABLE_HW_MULT = 1'b1,
  parameter bit ENABLE_HW_DIV  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_valid,
  input  logic [MD_OP_W-1:0]   op,
  input  logic [31:0]          op_a,
  input  logic [31:0]          op_b,
  input  logic                 ex_stall,
  input  logic                 ex_flush,
  output logic                 op_stall,
  output logic [31:0]          hilo_rdata,
  output logic [31:0]          hi,
  output logic [31:0]          lo,
  antares_muldiv_ctrl_if.master eng
);

  md_state_e   state_q, state_d;
  acc_mode_e   acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] eng_a_q, eng_a_d;
  logic [31:0] eng_b_q, eng_b_d;
  logic        mult_start_q, mult_start_d;
  logic        div_start_q, div_start_d;
  logic        mult_signed_q, mult_signed_d;
  logic        div_signed_q, div_signed_d;

  logic        busy;
  logic        accept;
  logic [63:0] hilo_cur;
  logic [63:0] hilo_new;

  // Stall depends only on op_valid/op and our own state, never on ex_stall
  assign busy     = (state_q != ST_IDLE);
  assign op_stall = op_valid & busy & (op != MD_OP_NONE);
  assign accept   = op_valid & ~op_stall & ~ex_stall & ~ex_flush;
  assign hilo_cur = {hi_q, lo_q};

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    eng_a_d       = eng_a_q;
    eng_b_d       = eng_b_q;
    mult_signed_d = mult_signed_q;
    div_signed_d  = div_signed_q;
    mult_start_d  = 1'b0;
    div_start_d   = 1'b0;
    hilo_new      = hilo_cur;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mult_class(op)) begin
            if (ENABLE_HW_MULT) begin
              state_d       = ST_MULT_WAIT;
              mult_start_d  = 1'b1;
              mult_signed_d = is_signed_op(op);
              acc_d         = acc_mode(op);
              eng_a_d       = op_a;
              eng_b_d       = op_b;
            end
          end else begin
            case (op)
              MD_OP_DIV, MD_OP_DIVU: begin
                // Zero divisor retires without touching HI/LO or the engine
                if (ENABLE_HW_DIV && (op_b != '0)) begin
                  state_d      = ST_DIV_WAIT;
                  div_start_d  = 1'b1;
                  div_signed_d = is_signed_op(op);
                  eng_a_d      = op_a;
                  eng_b_d      = op_b;
                end
              end
              MD_OP_MTHI: hi_d = op_a;
              MD_OP_MTLO: lo_d = op_a;
              default: ;
            endcase
          end
        end
      end

      ST_MULT_WAIT: begin
        // A done coinciding with our own start pulse cannot belong to this op
        if (eng.mult_done && !mult_start_q) begin
          case (acc_q)
            ACC_ADD: hilo_new = hilo_cur + eng.mult_result;
            ACC_SUB: hilo_new = hilo_cur - eng.mult_result;
            default: hilo_new = eng.mult_result;
          endcase
          hi_d    = hilo_new[63:32];
          lo_d    = hilo_new[31:0];
          state_d = ST_IDLE;
        end
      end

      ST_DIV_WAIT: begin
        if (eng.div_done && !div_start_q) begin
          hi_d    = eng.div_remainder;
          lo_d    = eng.div_quotient;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      acc_q         <= ACC_SET;
      hi_q          <= '0;
      lo_q          <= '0;
      eng_a_q       <= '0;
      eng_b_q       <= '0;
      mult_start_q  <= 1'b0;
      div_start_q   <= 1'b0;
      mult_signed_q <= 1'b0;
      div_signed_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      eng_a_q       <= eng_a_d;
      eng_b_q       <= eng_b_d;
      mult_start_q  <= mult_start_d;
      div_start_q   <= div_start_d;
      mult_signed_q <= mult_signed_d;
      div_signed_q  <= div_signed_d;
    end
  end

  always_comb begin
    hilo_rdata = '0;
    if (op == MD_OP_MFHI)      hilo_rdata = hi_q;
    else if (op == MD_OP_MFLO) hilo_rdata = lo_q;
  end

  assign hi              = hi_q;
  assign lo              = lo_q;
  assign eng.eng_a       = eng_a_q;
  assign eng.eng_b       = eng_b_q;
  assign eng.mult_start  = mult_start_q;
  assign eng.mult_signed = mult_signed_q;
  assign eng.div_start   = div_start_q;
  assign eng.div_signed  = div_signed_q;

endmodule

// File: tb/tb_antares_muldiv_ctrl.sv
// Directed + randomized bench for the HI/LO sequencer; the bench plays the engines
// and keeps an arithmetic model of {HI,LO}.
module tb_antares_muldiv_ctrl;
  import antares_muldiv_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         op_valid = 1'b0;
  logic [3:0]   op = MD_OP_NONE;
  logic [31:0]  op_a = '0;
  logic [31:0]  op_b = '0;
  logic         ex_stall = 1'b0;
  logic         ex_flush = 1'b0;
  logic         op_stall;
  logic [31:0]  hilo_rdata;
  logic [31:0]  hi;
  logic [31:0]  lo;

  int unsigned  n_checks = 0;
  int unsigned  n_err = 0;
  logic [63:0]  hilo_m = '0;

  antares_muldiv_ctrl_if eng_if ();

  antares_muldiv_ctrl #(
    .ENABLE_HW_MULT(1'b1),
    .ENABLE_HW_DIV (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .op_valid  (op_valid),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .ex_stall  (ex_stall),
    .ex_flush  (ex_flush),
    .op_stall  (op_stall),
    .hilo_rdata(hilo_rdata),
    .hi        (hi),
    .lo        (lo),
    .eng       (eng_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_signed(input logic [3:0] o);
    return o inside {MD_OP_MULT, MD_OP_DIV, MD_OP_MADD, MD_OP_MSUB};
  endfunction

  function automatic logic [63:0] ref_prod(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    if (m_signed(o)) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [3:0] o, input logic [63:0] hl);
    if (o == MD_OP_MFHI) return hl[63:32];
    if (o == MD_OP_MFLO) return hl[31:0];
    return 32'h0;
  endfunction

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Single-cycle ops: MTHI/MTLO/MFHI/MFLO
  task automatic quick_op(input logic [3:0] o, input logic [31:0] a);
    op_valid = 1'b1; op = o; op_a = a; op_b = $urandom;
    @(negedge clk);
    chk("quick_stall", 64'(op_stall), 64'(0));
    chk("quick_rdata", 64'(hilo_rdata), 64'(exp_rdata(o, hilo_m)));
    @(posedge clk); #1;
    op_valid = 1'b0; op = MD_OP_NONE;
    if (o == MD_OP_MTHI) hilo_m[63:32] = a;
    if (o == MD_OP_MTLO) hilo_m[31:0]  = a;
    @(negedge clk);
    chk("quick_hilo", {hi, lo}, hilo_m);
    chk("quick_starts", 64'({eng_if.mult_start, eng_if.div_start}), 64'(0));
    @(posedge clk); #1;
  endtask

  // Engine op: accept, start pulse, lat cycles later a done pulse, commit.
  // follow is an op (NONE/MFHI/MFLO) presented right behind it; early pulses
  // done in the start cycle, which must be ignored.
  task automatic engine_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int unsigned lat, input logic [3:0] follow, input bit early);
    bit          is_mul, is_div, launches, stall_exp;
    logic [63:0] old, p;
    logic [31:0] q, r;
    int          sa, sb;
    is_mul   = o inside {MD_OP_MULT, MD_OP_MULTU, MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU};
    is_div   = o inside {MD_OP_DIV, MD_OP_DIVU};
    launches = is_mul || (is_div && b != 0);
    stall_exp = (follow != MD_OP_NONE);
    old = hilo_m;
    p = ref_prod(o, a, b);
    q = '0; r = '0;
    if (is_div && b != 0) begin
      if (m_signed(o)) begin
        sa = $signed(a); sb = $signed(b);
        q = 32'(sa / sb); r = 32'(sa % sb);
      end else begin
        q = a / b; r = a % b;
      end
    end

    op_valid = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    chk("accept_stall", 64'(op_stall), 64'(0));
    @(posedge clk); #1;
    op_valid = stall_exp; op = follow; op_a = $urandom; op_b = $urandom;
    if (early) begin
      eng_if.mult_done = 1'b1; eng_if.mult_result = {$urandom, $urandom};
      eng_if.div_done = 1'b1; eng_if.div_quotient = $urandom; eng_if.div_remainder = $urandom;
    end
    @(negedge clk);
    chk("mult_start", 64'(eng_if.mult_start), 64'(is_mul));
    chk("div_start", 64'(eng_if.div_start), 64'(is_div && b != 0));
    if (is_mul) begin
      chk("mult_signed", 64'(eng_if.mult_signed), 64'(m_signed(o)));
      chk("eng_ab", {eng_if.eng_a, eng_if.eng_b}, {a, b});
    end
    if (is_div && b != 0) begin
      chk("div_signed", 64'(eng_if.div_signed), 64'(m_signed(o)));
      chk("eng_ab", {eng_if.eng_a, eng_if.eng_b}, {a, b});
    end
    if (!launches) begin
      chk("nolaunch_stall", 64'(op_stall), 64'(0));
      chk("nolaunch_hilo", {hi, lo}, old);
      chk("nolaunch_rdata", 64'(hilo_rdata), 64'(exp_rdata(follow, old)));
      @(posedge clk); #1;
      eng_if.mult_done = 1'b0; eng_if.div_done = 1'b0;
      op_valid = 1'b0; op = MD_OP_NONE;
      @(negedge clk);
      chk("nolaunch_hilo2", {hi, lo}, old);
      @(posedge clk); #1;
      return;
    end
    chk("wait_stall0", 64'(op_stall), 64'(stall_exp));
    for (int unsigned i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      eng_if.mult_done = 1'b0; eng_if.div_done = 1'b0;
      if (i == lat) begin
        if (is_mul) begin
          eng_if.mult_done = 1'b1; eng_if.mult_result = p;
        end else begin
          eng_if.div_done = 1'b1; eng_if.div_quotient = q; eng_if.div_remainder = r;
        end
      end
      @(negedge clk);
      chk("wait_starts", 64'({eng_if.mult_start, eng_if.div_start}), 64'(0));
      chk("wait_stall", 64'(op_stall), 64'(stall_exp));
      chk("wait_hilo", {hi, lo}, old);
      chk("wait_rdata", 64'(hilo_rdata), 64'(exp_rdata(follow, old)));
    end
    @(posedge clk); #1;
    eng_if.mult_done = 1'b0; eng_if.div_done = 1'b0;
    case (o)
      MD_OP_MULT, MD_OP_MULTU: hilo_m = p;
      MD_OP_MADD, MD_OP_MADDU: hilo_m = hilo_m + p;
      MD_OP_MSUB, MD_OP_MSUBU: hilo_m = hilo_m - p;
      default:                 hilo_m = {r, q};
    endcase
    @(negedge clk);
    chk("done_hilo", {hi, lo}, hilo_m);
    chk("done_stall", 64'(op_stall), 64'(0));
    chk("done_rdata", 64'(hilo_rdata), 64'(exp_rdata(follow, hilo_m)));
    @(posedge clk); #1;
    op_valid = 1'b0; op = MD_OP_NONE;
  endtask

  initial begin
    logic [3:0]  mult_ops [6];
    logic [3:0]  fol [3];
    logic [3:0]  o;
    logic [31:0] a, b;
    mult_ops = '{MD_OP_MULT, MD_OP_MULTU, MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU};
    fol = '{MD_OP_NONE, MD_OP_MFHI, MD_OP_MFLO};
    eng_if.mult_done = 1'b0; eng_if.mult_result = '0;
    eng_if.div_done = 1'b0; eng_if.div_quotient = '0; eng_if.div_remainder = '0;

    repeat (3) idle_cycle();
    @(negedge clk);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_eng", {eng_if.eng_a, eng_if.eng_b}, 64'h0);
    chk("rst_ctl", 64'({eng_if.mult_start, eng_if.mult_signed, eng_if.div_start, eng_if.div_signed, op_stall}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    idle_cycle();

    // Accumulate wrap across the HI/LO boundary
    quick_op(MD_OP_MTHI, 32'd5);
    quick_op(MD_OP_MTLO, 32'hFFFF_FFFF);
    engine_op(MD_OP_MADDU, 32'd1, 32'd1, 2, MD_OP_NONE, 1'b0);
    chk("maddu_const", {hi, lo}, 64'h6_0000_0000);
    engine_op(MD_OP_MSUB, 32'd1, 32'd1, 1, MD_OP_MFHI, 1'b0);
    chk("msub_const", {hi, lo}, 64'h5_FFFF_FFFF);

    engine_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 3, MD_OP_MFLO, 1'b1);
    chk("multu_const", {hi, lo}, 64'h1_FFFF_FFFE);

    engine_op(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 2, MD_OP_MFHI, 1'b0);
    chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    engine_op(MD_OP_DIVU, 32'd1234, 32'd0, 2, MD_OP_MFHI, 1'b1);

    // Flushed MULT is dropped
    op_valid = 1'b1; op = MD_OP_MULT; op_a = 32'd3; op_b = 32'd4; ex_flush = 1'b1;
    @(posedge clk); #1;
    ex_flush = 1'b0; op = MD_OP_MFHI;
    @(negedge clk);
    chk("flush_start", 64'(eng_if.mult_start), 64'(0));
    chk("flush_stall", 64'(op_stall), 64'(0));
    @(posedge clk); #1;
    op_valid = 1'b0; op = MD_OP_NONE;

    // Held MULT under ex_stall launches once, after the stall drops
    op_valid = 1'b1; op = MD_OP_MULT; op_a = 32'hFFFF_FFFD; op_b = 32'd7; ex_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("exstall_start", 64'(eng_if.mult_start), 64'(0));
      chk("exstall_opstall", 64'(op_stall), 64'(0));
    end
    @(posedge clk); #1;
    ex_stall = 1'b0;
    engine_op(MD_OP_MULT, 32'hFFFF_FFFD, 32'd7, 2, MD_OP_NONE, 1'b0);
    @(negedge clk);
    chk("exstall_one_start", 64'(eng_if.mult_start), 64'(0));
    @(posedge clk); #1;

    for (int n = 0; n < 30; n++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0, 1: engine_op(mult_ops[$urandom_range(0, 5)], a, b, $urandom_range(1, 4),
                        fol[$urandom_range(0, 2)], 1'($urandom_range(0, 1)));
        2: begin
          o = ($urandom_range(0, 1) != 0) ? MD_OP_DIV : MD_OP_DIVU;
          if ($urandom_range(0, 4) == 0) b = '0;
          else if ($urandom_range(0, 1) != 0) b = 32'($urandom_range(1, 300));
          if (o == MD_OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
          engine_op(o, a, b, $urandom_range(1, 4), fol[$urandom_range(0, 2)], 1'($urandom_range(0, 1)));
        end
        3: quick_op(MD_OP_MTHI, a);
        4: quick_op(MD_OP_MTLO, a);
        default: quick_op(($urandom_range(0, 1) != 0) ? MD_OP_MFHI : MD_OP_MFLO, a);
      endcase
    end

    // Reset while the divider is busy, then a stray done
    op_valid = 1'b1; op = MD_OP_DIV; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    op_valid = 1'b0; op = MD_OP_NONE;
    @(negedge clk);
    chk("rstmid_start", 64'(eng_if.div_start), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    hilo_m = '0;
    op_valid = 1'b1; op = MD_OP_MFHI;
    @(negedge clk);
    chk("rstmid_stall", 64'(op_stall), 64'(0));
    chk("rstmid_hilo", {hi, lo}, 64'h0);
    chk("rstmid_eng", {eng_if.eng_a, eng_if.eng_b}, 64'h0);
    @(posedge clk); #1;
    op_valid = 1'b0; op = MD_OP_NONE;
    eng_if.div_done = 1'b1; eng_if.div_quotient = 32'd14; eng_if.div_remainder = 32'd2;
    @(posedge clk); #1;
    eng_if.div_done = 1'b0;
    @(negedge clk);
    chk("stray_done_hilo", {hi, lo}, hilo_m);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/antares_muldiv_ctrl.md
# antares_muldiv_ctrl

Sequencer and owner of the HI/LO register pair for the Antares EX stage. It accepts multiply, divide, multiply-accumulate and HI/LO move operations from the ALU, and launches them on external multiplier and divider engines through start/done handshakes. It writes engine results into HI/LO and stalls later HI/LO consumers until the in-flight operation retires. MULT and DIV retire from the pipeline in one cycle; only subsequent HI/LO accesses wait.

## Interface
- ENABLE_HW_MULT, 1, 0: mult-class ops complete immediately with HI/LO unchanged, mult_start never asserts
- ENABLE_HW_DIV, 1, 0: same for div-class ops and div_start
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- op_valid  in  1  EX holds a HI/LO-class operation
- op  in  4  operation code (MD_OP_* from shared defines)
- op_a  in  32  rs operand
- op_b  in  32  rt operand
- ex_stall  in  1  pipeline stalled by another source
- ex_flush  in  1  EX instruction cancelled
- op_stall  out  1  stall request to hazard unit
- hilo_rdata  out  32  HI (MFHI) or LO (MFLO), else 0
- hi, lo  out  32 each  architectural HI/LO
- eng_a, eng_b  out  32 each  latched operands for engines
- mult_start  out  1  one-cycle start pulse
- mult_signed  out  1  signed multiply
- mult_done  in  1  one-cycle completion pulse
- mult_result  in  64  product
- div_start  out  1  one-cycle start pulse
- div_signed  out  1  signed divide
- div_done  in  1  one-cycle completion pulse
- div_quotient, div_remainder  in  32 each  results

## Operation
- States: IDLE, MULT_WAIT, DIV_WAIT.
- Accept condition: op_valid & ~op_stall & ~ex_stall & ~ex_flush.
- Busy is state != IDLE. op_stall = op_valid & busy for every op except MD_OP_NONE. op_stall never depends on ex_stall (no loop).
- IDLE accept:
  - MULT/MULTU/MADD/MADDU/MSUB/MSUBU: latch operands and kind, go to MULT_WAIT.
  - DIV/DIVU with op_b != 0: latch, go to DIV_WAIT.
  - DIV/DIVU with op_b == 0: no engine start, HI/LO unchanged, stay IDLE.
  - MTHI: hi <= op_a. MTLO: lo <= op_a.
  - MFHI/MFLO: no state change.
- mult_start/div_start are registered and assert exactly in the first cycle of the WAIT state. A done pulse in that same cycle is ignored; engines have latency ≥ 1.
- MULT_WAIT on mult_done, at the same edge:
  - MULT/MULTU: {hi,lo} <= mult_result.
  - MADD/MADDU: {hi,lo} <= {hi,lo} + mult_result.
  - MSUB/MSUBU: {hi,lo} <= {hi,lo} − mult_result.
  - Go to IDLE. 64-bit arithmetic wraps mod 2^64; no overflow flag.
- DIV_WAIT on div_done: hi <= div_remainder, lo <= div_quotient, go to IDLE.
- Done pulses outside the matching WAIT state are ignored.
- ex_flush cancels only the op presented that cycle. An accepted op always completes and commits.
- hilo_rdata is combinational from current hi/lo when op is MFHI/MFLO, regardless of stall.

## Timing
- Reset values: state IDLE; hi, lo, eng_a, eng_b 0; all start and signed outputs 0; op_stall 0.
- Accept at edge T, start pulse in cycle T+1. Done in cycle D ≥ T+2 updates HI/LO at edge D. A stalled MFHI/MFLO is accepted in cycle D+1 and sees the new value.
- MTHI/MTLO: value visible in hi/lo from the cycle after acceptance.
- Reset mid-operation returns to IDLE immediately. A later done pulse is ignored.
- Disabled engine: the op completes in its accept cycle and HI/LO is unchanged.

## Structure
- MD_OP_* codes (4-bit) and state encodings go in the shared defines header next to the ALU_OP_* codes.
- No sub-module. The 64-bit add/sub accumulator is inline. The engines are instantiated by the parent ALU and connected through the handshake ports.

## Test plan
- MULTU 0xFFFFFFFF×2, engine done 3 cycles after start → {hi,lo} = 0x1_FFFFFFFE at the done edge; MFLO issued the next cycle is stalled until done, then returns 0xFFFFFFFE.
- DIV −7/2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; div_signed=1; op_stall high on a following MFHI exactly until div_done.
- DIVU x/0 → no div_start, HI/LO unchanged, op_stall never asserts.
- MTHI 5, MTLO 0xFFFFFFFF, then MADDU 1×1 → {hi,lo} = 0x6_00000000. Then MSUB 1×1 → 0x5_FFFFFFFF.
- MULT presented with ex_flush=1 → no start, state stays IDLE. Presented with ex_stall=1 for 2 cycles → exactly one start, after the stall drops.
- Reset asserted during DIV_WAIT, then a stray div_done → state IDLE, HI/LO = 0, no write.
